// File: rtl/instr_encode.sv
// ---------------------------------------------------------------------------
// instr_encode
//
// Pipelined RV32I instruction encoder. This is the inverse of the decode-stage
// immediate extender. Instruction fields and a full 32-bit immediate enter
// with a format code. The immediate is scattered into its format-specific bit
// positions, and the resulting 32-bit word leaves on a valid/ready stream.
//
// Pipeline:
//   S1 registers the input fields on accept.
//   S2 registers the encoded word and its error flag.
//   Each stage has its own valid bit. in_ready is combinational from out_ready.
//
// Configuration macro: INSTR_ENCODE_IMM_CHECK_EN
//   defined   : immediates are checked for range and alignment.
//               An unencodable immediate raises out_err.
//   undefined : immediates are truncated into their fields.
//               out_err flags only the invalid format codes 101 and 110.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   input fields valid
//   in_ready   out  encoder accepts this cycle
//   in_immSrc  in   [2:0] format code
//                     000 I, 001 S, 010 B, 011 J, 100 U, 111 R
//   in_opcode  in   [6:0] instruction bits [6:0]
//   in_rd      in   [4:0] bits [11:7]   (I/U/J/R)
//   in_funct3  in   [2:0] bits [14:12]  (I/S/B/R)
//   in_rs1     in   [4:0] bits [19:15]  (I/S/B/R)
//   in_rs2     in   [4:0] bits [24:20]  (S/B/R)
//   in_funct7  in   [6:0] bits [31:25]  (R)
//   in_imm     in   [31:0] sign-extended immediate (byte offset for B/J)
//   out_valid  out  encoded word valid
//   out_ready  in   downstream accepts
//   out_instr  out  [31:0] encoded instruction (NOP on error)
//   out_err    out  1 = unencodable input
//   enc_count  out  [CNT_W-1:0] handoffs, wraps
//   err_count  out  [7:0] handoffs with out_err set, saturates at 255
// ---------------------------------------------------------------------------
module instr_encode #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_immSrc,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [7:0]       err_count
);

   // Format codes shared with the decode-stage immediate extender.
   typedef enum logic [2:0] {
      FMT_I = 3'b000,
      FMT_S = 3'b001,
      FMT_B = 3'b010,
      FMT_J = 3'b011,
      FMT_U = 3'b100,
      FMT_R = 3'b111
   } fmt_e;

   // Canonical NOP (addi x0, x0, 0). It replaces any word that cannot be
   // encoded.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // ------------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------------
   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_fmt_q;
   logic [6:0]       s1_opcode_q;
   logic [4:0]       s1_rd_q;
   logic [2:0]       s1_funct3_q;
   logic [4:0]       s1_rs1_q;
   logic [4:0]       s1_rs2_q;
   logic [6:0]       s1_funct7_q;
   logic [31:0]      s1_imm_q;

   logic             s2_valid_q, s2_valid_d;
   logic [31:0]      s2_instr_q, s2_instr_d;
   logic             s2_err_q, s2_err_d;

   logic [CNT_W-1:0] enc_count_q, enc_count_d;
   logic [7:0]       err_count_q, err_count_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic s2_adv;
   logic s1_adv;
   logic accept;
   logic handoff;

   // S2 can take a new word when it is empty or is being drained this cycle.
   // S1 can take a new word under the same condition, applied to itself.
   // in_ready deliberately ignores in_valid. This avoids a combinational loop
   // with an upstream that waits for ready before asserting valid.
   assign s2_adv   = !s2_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = !s1_valid_q | s2_adv;
   assign accept   = in_valid & in_ready;
   assign handoff  = s2_valid_q & out_ready;

   // ------------------------------------------------------------------------
   // Immediate scatter (from S1 registers)
   // ------------------------------------------------------------------------
   logic [31:0] enc_word;
   logic        fmt_ok;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first.
      // Any path through the case that misses an assignment would otherwise
      // infer a latch.
      enc_word = NOP_INSTR;
      fmt_ok   = 1'b1;
      case (s1_fmt_q)
         FMT_I: enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q,
                            s1_rd_q, s1_opcode_q};
         FMT_S: enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                            s1_funct3_q, s1_imm_q[4:0], s1_opcode_q};
         FMT_B: enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q,
                            s1_rs1_q, s1_funct3_q, s1_imm_q[4:1],
                            s1_imm_q[11], s1_opcode_q};
         FMT_J: enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                            s1_imm_q[19:12], s1_rd_q, s1_opcode_q};
         FMT_U: enc_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
         FMT_R: enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q,
                            s1_funct3_q, s1_rd_q, s1_opcode_q};
         default: fmt_ok = 1'b0;   // codes 101 and 110
      endcase
   end

   // ------------------------------------------------------------------------
   // Encodability check
   // ------------------------------------------------------------------------
   logic imm_ok;

`ifdef INSTR_ENCODE_IMM_CHECK_EN
   // A field of width w holds the immediate only when every bit above w-1
   // equals the field's sign bit. This means the bits from the sign position
   // upward must be all ones or all zeros.
   logic sext_12;   // imm[31:11] uniform: fits I/S
   logic sext_13;   // imm[31:12] uniform: fits B
   logic sext_21;   // imm[31:20] uniform: fits J

   assign sext_12 = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
   assign sext_13 = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
   assign sext_21 = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

   always_comb begin
      imm_ok = 1'b1;
      case (s1_fmt_q)
         FMT_I, FMT_S: imm_ok = sext_12;
         FMT_B:        imm_ok = sext_13 & ~s1_imm_q[0];
         FMT_J:        imm_ok = sext_21 & ~s1_imm_q[0];
         FMT_U:        imm_ok = ~(|s1_imm_q[11:0]);
         default:      imm_ok = 1'b1;   // R ignores imm; bad codes flagged above
      endcase
   end
`else
   assign imm_ok = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s2_valid_d  = s2_valid_q;
      s2_instr_d  = s2_instr_q;
      s2_err_d    = s2_err_q;
      enc_count_d = enc_count_q;
      err_count_d = err_count_q;

      // While S1 is open, its valid tracks in_valid.
      // Holding in_valid low drains S1.
      if (in_ready) begin
         s1_valid_d = in_valid;
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end

      if (s1_adv) begin
         s2_err_d   = ~fmt_ok | ~imm_ok;
         s2_instr_d = (~fmt_ok | ~imm_ok) ? NOP_INSTR : enc_word;
      end

      if (handoff) begin
         enc_count_d = enc_count_q + CNT_W'(1);
         if (s2_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, whatever the statement order.
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_instr_q  <= '0;
         s2_err_q    <= 1'b0;
         enc_count_q <= '0;
         err_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         s2_instr_q  <= s2_instr_d;
         s2_err_q    <= s2_err_d;
         enc_count_q <= enc_count_d;
         err_count_q <= err_count_d;
      end
   end

   // NOTE: the S1 payload is not reset. It is only ever consumed when
   // s1_valid_q is set, so clearing it would add reset fan-out without
   // changing behaviour.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_fmt_q    <= in_immSrc;
         s1_opcode_q <= in_opcode;
         s1_rd_q     <= in_rd;
         s1_funct3_q <= in_funct3;
         s1_rs1_q    <= in_rs1;
         s1_rs2_q    <= in_rs2;
         s1_funct7_q <= in_funct7;
         s1_imm_q    <= in_imm;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_instr = s2_instr_q;
   assign out_err   = s2_err_q;
   assign enc_count = enc_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encode.sv
module tb_instr_encode;

   localparam int CNT_W = 16;
   localparam int BOUND = 20;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_immSrc;
   logic [6:0]       in_opcode;
   logic [4:0]       in_rd;
   logic [2:0]       in_funct3;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic [6:0]       in_funct7;
   logic [31:0]      in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [CNT_W-1:0] enc_count;
   logic [7:0]       err_count;

   int checks   = 0;
   int failures = 0;
   int exp_enc  = 0;
   int exp_errc = 0;

   instr_encode #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_immSrc (in_immSrc),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_funct3 (in_funct3),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   // Outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op,
                             input logic [4:0] rd, input logic [2:0] f3,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [6:0] f7, input logic [31:0] imm);
      in_immSrc = fmt;
      in_opcode = op;
      in_rd     = rd;
      in_funct3 = f3;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct7 = f7;
      in_imm    = imm;
   endtask

   // Offers the current fields. It returns just after the accepting edge,
   // with in_valid already dropped.
   task automatic send(input string tag);
      int n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < BOUND) begin
         step();
         n++;
      end
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Waits, with a bound, for out_valid, then checks the word. The handoff
   // happens on the next edge when out_ready is high.
   task automatic expect_out(input string tag, input logic [31:0] instr, input logic err);
      int n = 0;
      while (!out_valid && n < BOUND) begin
         step();
         n++;
      end
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_instr"}, out_instr, instr);
      check({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_enc_count"}, 32'(enc_count), 32'(exp_enc));
      check({tag, "_err_count"}, 32'(err_count), 32'(exp_errc));
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_fields(3'b000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
      step();
      step();
      reset = 1'b0;

      // ---------------- reset state ----------------
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_err",   {31'd0, out_err}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      check_counts("rst");

      // ---------------- I-type, two-stage latency ----------------
      set_fields(3'b000, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
      send("i");
      check("i_lat_s1_only", {31'd0, out_valid}, 32'd0);
      step();
      check("i_lat_valid", {31'd0, out_valid}, 32'd1);
      check("i_instr", out_instr, 32'hFFF0_0093);
      check("i_err",   {31'd0, out_err}, 32'd0);
      step();
      exp_enc = 1;
      check_counts("i");

      // ---------------- B-type ----------------
      set_fields(3'b010, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
      send("b");
      expect_out("b", 32'hFE20_8EE3, 1'b0);
      step();
      exp_enc++;
      check_counts("b");

      // ---------------- back-to-back U then J ----------------
      set_fields(3'b100, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
      in_valid = 1'b1;
      check("uj_ready_u", {31'd0, in_ready}, 32'd1);
      step();
      set_fields(3'b011, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800);
      check("uj_ready_j", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("uj_u_valid", {31'd0, out_valid}, 32'd1);
      check("uj_u_instr", out_instr, 32'h1234_52B7);
      step();
      check("uj_j_valid", {31'd0, out_valid}, 32'd1);
      check("uj_j_instr", out_instr, 32'h0010_00EF);
      step();
      check("uj_drained", {31'd0, out_valid}, 32'd0);
      exp_enc += 2;
      check_counts("uj");

      // ---------------- misaligned B immediate ----------------
      set_fields(3'b010, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
      send("berr");
`ifdef INSTR_ENCODE_IMM_CHECK_EN
      expect_out("berr", 32'h0000_0013, 1'b1);
      exp_errc++;
`else
      // imm[0] is dropped and imm[1] lands in bit 8.
      expect_out("berr", 32'h0000_0163, 1'b0);
`endif
      step();
      exp_enc++;
      check_counts("berr");

      // ---------------- U immediate with low bits set ----------------
      set_fields(3'b100, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5001);
      send("uerr");
`ifdef INSTR_ENCODE_IMM_CHECK_EN
      expect_out("uerr", 32'h0000_0013, 1'b1);
      exp_errc++;
`else
      expect_out("uerr", 32'h1234_52B7, 1'b0);
`endif
      step();
      exp_enc++;

      // ---------------- invalid format codes ----------------
      set_fields(3'b101, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
      send("fmt101");
      expect_out("fmt101", 32'h0000_0013, 1'b1);
      step();
      exp_enc++;
      exp_errc++;
      set_fields(3'b110, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
      send("fmt110");
      expect_out("fmt110", 32'h0000_0013, 1'b1);
      step();
      exp_enc++;
      exp_errc++;
      check_counts("fmt");

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      set_fields(3'b111, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hDEAD_BEEF);  // add x3,x1,x2
      in_valid = 1'b1;
      check("bp_rdy_a", {31'd0, in_ready}, 32'd1);
      step();
      set_fields(3'b111, 7'h33, 5'd4, 3'd0, 5'd2, 5'd3, 7'h20, 32'd0);          // sub x4,x2,x3
      check("bp_rdy_b", {31'd0, in_ready}, 32'd1);
      step();
      set_fields(3'b001, 7'h23, 5'd31, 3'd2, 5'd1, 5'd2, 7'h7F, 32'd8);         // sw x2,8(x1)
      for (int i = 0; i < 3; i++) begin
         check("bp_full_rdy",  {31'd0, in_ready}, 32'd0);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_instr", out_instr, 32'h0020_81B3);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_rdy_release", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_b_instr", out_instr, 32'h4031_0233);
      step();
      check("bp_c_valid", {31'd0, out_valid}, 32'd1);
      check("bp_c_instr", out_instr, 32'h0020_A423);
      step();
      check("bp_drained", {31'd0, out_valid}, 32'd0);
      exp_enc += 3;
      check_counts("bp");

      // ---------------- reset mid-stream ----------------
      out_ready = 1'b0;
      set_fields(3'b000, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
      in_valid = 1'b1;
      step();
      set_fields(3'b000, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd6);
      step();
      in_valid = 1'b0;
      check("mid_full_valid", {31'd0, out_valid}, 32'd1);
      check("mid_full_rdy",   {31'd0, in_ready}, 32'd0);
      reset = 1'b1;
      step();
      reset     = 1'b0;
      out_ready = 1'b1;
      exp_enc   = 0;
      exp_errc  = 0;
      check("mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_out_instr", out_instr, 32'd0);
      check("mid_in_ready",  {31'd0, in_ready}, 32'd1);
      check_counts("mid");
      set_fields(3'b000, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
      send("post");
      check("post_lat_s1_only", {31'd0, out_valid}, 32'd0);
      step();
      check("post_valid", {31'd0, out_valid}, 32'd1);
      check("post_instr", out_instr, 32'hFFF0_0093);
      step();
      exp_enc = 1;
      check_counts("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encode.md
# instr_encode

Pipelined RV32I instruction encoder, the inverse of the decode-stage immediate extender. It accepts instruction fields plus a full 32-bit immediate tagged with the same `immSrc` format code, and scatters the immediate into its format-specific bit positions. It also checks that the immediate is encodable, and emits a 32-bit instruction word over a valid/ready stream. It feeds the boot/self-test instruction generator and the core's instruction-memory loader.

## Interface
Parameters:
- `CNT_W`, 16: width of the encoded-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder accepts this cycle.
- `in_immSrc` in 3: format code.
  - 000 I, 001 S, 010 B, 011 J, 100 U, 111 R (no immediate).
  - 101 and 110 are invalid.
- `in_opcode` in 7: instruction bits [6:0].
- `in_rd` in 5: bits [11:7]; used by I/U/J/R only.
- `in_funct3` in 3: bits [14:12]; used by I/S/B/R only.
- `in_rs1` in 5: bits [19:15]; used by I/S/B/R only.
- `in_rs2` in 5: bits [24:20]; used by S/B/R only.
- `in_funct7` in 7: bits [31:25]; used by R only.
- `in_imm` in 32: sign-extended immediate, byte offset for B/J.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: downstream accepts.
- `out_instr` out 32: encoded instruction.
- `out_err` out 1: qualifies `out_instr`; 1 = unencodable input.
- `enc_count` out CNT_W: instructions handed off (out_valid & out_ready), wraps.
- `err_count` out 8: handoffs with `out_err` = 1; saturates at 255.

## Operation
- **Stage 1 (S1):** registers input fields on accept.
- **Stage 2 (S2):** registers the encoded word and error flag from S1.
- Each stage has its own valid bit.

Immediate placement (mirror of decode):
- I: [31:20] = imm[11:0].
- S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
- B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
- J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
- U: [31:12] = imm[31:12].
- R: no immediate; funct7/rs2/rs1/funct3/rd placed normally.
- Bits a format does not define come from the field ports listed above. Unused ports for that format are ignored.

Encodability checks (with IMM_CHECK_EN):
- I/S: imm[31:11] all equal.
- B: imm[31:12] all equal and imm[0] = 0.
- J: imm[31:20] all equal and imm[0] = 0.
- U: imm[11:0] = 0.
- R: imm ignored.

Error behaviour:
- An invalid format code always sets the error.
- On error: `out_instr` = 32'h0000_0013 (canonical NOP), `out_err` = 1.
- The word still flows through the pipeline in order; it is not dropped.

## Timing
- **Latency:** an input accepted at edge N is presented at `out_valid` from cycle N+1, i.e. 2 register stages. Throughput is 1 per cycle with `out_ready` held high.
- **S2 advance:** `s2_adv` = !s2_valid | out_ready.
- **S1 advance:** `s1_adv` = s1_valid & s2_adv.
- **Input ready:** `in_ready` = !s1_valid | s2_adv.
  - This is a combinational path from `out_ready`; it is permitted and must not depend on `in_valid`.
- **Output hold:** while out_valid & !out_ready, `out_instr`, `out_err` and `out_valid` hold stable.
- **Full:** both stages valid and `out_ready` = 0 → `in_ready` = 0. No input is lost or duplicated.
- **Simultaneous events:** input accept, S1→S2 move and output handoff all occur in the same cycle when `in_ready` and `out_ready` are both 1.
- **Counters:** update on the handoff edge.
  - `enc_count` wraps from 2^CNT_W−1 to 0.
  - `err_count` holds at 255.
- **Reset values:** out_valid 0, in_ready 1 (the cycle after reset), out_instr 0, out_err 0, enc_count 0, err_count 0, both stage valids 0.
- **Reset mid-operation:** in-flight words are discarded without a handoff and counters clear. The first accept is possible the cycle after `reset` deasserts.

## Configuration
- Macro `INSTR_ENCODE_IMM_CHECK_EN`.
- **Defined:** the encodability checks above apply.
- **Undefined:**
  - No range or alignment checks.
  - Immediates are truncated into their fields, and imm[0] of B/J is dropped.
  - `out_err` is set only for invalid format codes (101, 110).
  - The check logic is absent; `err_count` remains.

## Test plan
- **I-type:** immSrc=000, opcode=0x13, rd=1, funct3=0, rs1=0, imm=0xFFFFFFFF, out_ready=1 → out_instr=0xFFF00093, out_err=0, 2 cycles after accept; enc_count=1.
- **B-type:** immSrc=010, opcode=0x63, funct3=0, rs1=1, rs2=2, imm=0xFFFFFFFC → out_instr=0xFE208EE3.
- **Back-to-back U then J, out_ready=1:**
  - U: opcode=0x37, rd=5, imm=0x12345000.
  - J: opcode=0x6F, rd=1, imm=0x800.
  - → 0x123452B7 then 0x001000EF on consecutive cycles.
- **Errors:**
  - B-type imm=3 with macro defined → out_err=1, out_instr=0x00000013, err_count=1.
  - immSrc=101 → out_err=1 regardless of macro.
- **Backpressure:** hold out_ready=0 and offer 3 valid inputs → exactly 2 accepted, then in_ready=0. Raise out_ready → outputs emerge in input order with no duplication; the third input is accepted on the first cycle out_ready=1.
- **Reset mid-stream:** assert reset with both stages full → next cycle out_valid=0, counters=0. The next input is encoded correctly with 2-cycle latency.
